fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction byte fetcher and length-decoding queue for an 8080-style front end.
// Pulls two bytes per memory request into a circular byte FIFO. It presents whole 1..3 byte
// instructions to the decode stage with a valid/ready handshake.
//
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   imem_req/addr    two-byte fetch request at a byte address (odd addresses allowed)
//   imem_valid/data  response one cycle after the request, [7:0]=mem[addr], [15:8]=mem[addr+1]
//   inst             {opcode, low byte, high byte}; bytes beyond inst_len read as zero
//   inst_pc/len      address of the opcode byte and instruction length (1..3)
//   inst_valid/ready transfer handshake towards decode
//   redirect/_pc     flush everything and restart fetch and dispatch at redirect_pc
module fetch_queue #(
  parameter int unsigned QDEPTH = 6
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic [23:0] inst,
  output logic [15:0] inst_pc,
  output logic [1:0]  inst_len,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  localparam int unsigned PtrW = $clog2(QDEPTH);
  localparam int unsigned CntW = $clog2(QDEPTH + 1);
  localparam logic [PtrW:0]   DepthP = (PtrW + 1)'(QDEPTH);
  localparam logic [CntW-1:0] DepthC = CntW'(QDEPTH);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [QDEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            pend_q, pend_d;
  logic [15:0]     fetch_pc_q, fetch_pc_d, inst_pc_q, inst_pc_d;

  logic [7:0]      b0, b1, b2;
  logic [1:0]      head_len;
  logic            xfer, enq, halt_now;
  logic [CntW-1:0] add_n, sub_n;

  // Pointer increment modulo QDEPTH; n never exceeds 3, so one correction suffices.
  function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] p, input logic [1:0] n);
    logic [PtrW:0] s;
    s = {1'b0, p} + {{(PtrW - 1){1'b0}}, n};
    if (s >= DepthP) s = s - DepthP;
    return s[PtrW-1:0];
  endfunction

  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] l;
    casez (op)
      8'b00??0001,                           // LXI
      8'b0010?010, 8'b0011?010,              // SHLD LHLD STA LDA
      8'b11000011, 8'b11001101,              // JMP CALL
      8'b11???010, 8'b11???100: l = 2'd3;    // Jccc Cccc
      8'b00???110,                           // MVI
      8'b11???110,                           // ADI ACI SUI SBI ANI XRI ORI CPI
      8'b11011011, 8'b11010011: l = 2'd2;    // IN OUT
      default:                  l = 2'd1;
    endcase
    return l;
  endfunction

  always_comb begin
    b0       = mem_q[head_q];
    b1       = mem_q[ptr_add(head_q, 2'd1)];
    b2       = mem_q[ptr_add(head_q, 2'd2)];
    head_len = op_len(b0);
  end

  // Decode-side outputs. Bytes within inst_len are always inside the occupied region,
  // so later enqueues at the tail never disturb a held instruction.
  always_comb begin
    inst_valid = (count_q != '0) && (count_q >= {{(CntW - 2){1'b0}}, head_len});
    inst_len   = (count_q == '0) ? 2'd1 : head_len;
    inst_pc    = inst_pc_q;
    inst       = '0;
    if (inst_valid) begin
      inst = {b0, (head_len >= 2'd2) ? b1 : 8'h00, (head_len == 2'd3) ? b2 : 8'h00};
    end
  end

  assign xfer     = inst_valid && inst_ready && !redirect;
  assign halt_now = xfer && (b0 == 8'h76);
  // A response only counts if we are still waiting for it; flushes clear pend_q.
  assign enq      = imem_valid && pend_q && !redirect && !halt_now;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StRun;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (redirect)      state_d = StRun;
    else if (halt_now) state_d = StHalted;
  end

  // FSM: outputs
  always_comb begin
    imem_req  = !rst && (state_q == StRun) && !pend_q && !redirect &&
                (count_q <= DepthC - CntW'(2));
    imem_addr = fetch_pc_q;
  end

  // Queue and program-counter next state
  always_comb begin
    add_n      = enq  ? CntW'(2) : '0;
    sub_n      = xfer ? CntW'(head_len) : '0;
    head_d     = xfer ? ptr_add(head_q, head_len) : head_q;
    tail_d     = enq ? ptr_add(tail_q, 2'd2) : tail_q;
    count_d    = count_q + add_n - sub_n;
    pend_d     = imem_req || (pend_q && !imem_valid);
    fetch_pc_d = imem_req ? fetch_pc_q + 16'd2 : fetch_pc_q;
    inst_pc_d  = xfer ? inst_pc_q + {14'b0, head_len} : inst_pc_q;
    if (redirect) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      pend_d     = 1'b0;
      fetch_pc_d = redirect_pc;
      inst_pc_d  = redirect_pc;
    end else if (halt_now) begin
      // Drop the queue and any request still in flight, including one issued this cycle.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      pend_q     <= 1'b0;
      fetch_pc_q <= 16'h0000;
      inst_pc_q  <= 16'h0000;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      fetch_pc_q <= fetch_pc_d;
      inst_pc_q  <= inst_pc_d;
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[tail_q]                <= imem_data[7:0];
      mem_q[ptr_add(tail_q, 2'd1)] <= imem_data[15:8];
    end
  end

endmodule
